// File: rtl/rr_dispatcher_pkg.sv
// Shared types for the one-to-N round-robin stream dispatcher.
package rr_dispatcher_pkg;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/rr_pick.sv
// Masked rotate-priority picker: first enabled index at or after start, wrapping.
module rr_pick #(
   parameter  int N  = 4,
   localparam int PW = $clog2(N)
) (
   input  logic [N-1:0]  en,
   input  logic [PW-1:0] start,
   output logic [PW-1:0] idx,
   output logic          found
);

   logic [N-1:0]   lo_mask;
   logic [2*N-1:0] dbl;

   always_comb begin
      for (int i = 0; i < N; i++) lo_mask[i] = (i < int'(start));
   end

   // Lower copy hides entries below start; the upper copy supplies the wrap-around.
   assign dbl = {en, en & ~lo_mask};

   // Scan from the top so the lowest set position wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int k = 2*N-1; k >= 0; k--) begin
         if (dbl[k]) begin
            found = 1'b1;
            idx   = PW'(k % N);
         end
      end
   end

endmodule

// File: rtl/rr_dispatcher.sv
// One-to-N round-robin stream dispatcher with a single-entry output register.
// Define RR_DISPATCHER_PKT_EN for per-packet routing with s_last_i/m_last_o.
module rr_dispatcher
   import rr_dispatcher_pkg::*;
#(
   parameter  int SLAVE_NUM  = 4,
   parameter  int DATA_WIDTH = 32,
   localparam int PTR_WIDTH  = $clog2(SLAVE_NUM)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [SLAVE_NUM-1:0]  en_i,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   output logic [SLAVE_NUM-1:0]  m_valid_o,
   input  logic [SLAVE_NUM-1:0]  m_ready_i,
   output logic [DATA_WIDTH-1:0] m_data_o,
   output logic [PTR_WIDTH-1:0]  m_sel_o
`ifdef RR_DISPATCHER_PKT_EN
   ,
   input  logic                  s_last_i,
   output logic                  m_last_o
`endif
);

   state_t                 state, state_nxt;
   logic [PTR_WIDTH-1:0]   ptr, tgt, tgt_inc, pick_start, pick_idx, new_tgt;
   logic                   pick_found;
   logic                   xfer, slot_free, accept, ptr_adv;

   assign tgt_inc    = (tgt == PTR_WIDTH'(SLAVE_NUM-1)) ? '0 : tgt + 1'b1;
   // When the slot refills in the same cycle it drains, the search starts after the draining target.
   assign pick_start = (state == ST_FULL) ? tgt_inc : ptr;

   rr_pick #(.N(SLAVE_NUM)) u_pick (
      .en    (en_i),
      .start (pick_start),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign xfer      = (state == ST_FULL) & m_ready_i[tgt];
   assign slot_free = (state == ST_EMPTY) | xfer;
   assign accept    = s_valid_i & s_ready_o;

`ifdef RR_DISPATCHER_PKT_EN
   logic in_pkt, last_q;

   // Mid-packet beats follow the packet's target regardless of the current enables.
   assign new_tgt  = in_pkt ? tgt : pick_idx;
   assign ptr_adv  = xfer & last_q;
   assign m_last_o = last_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         in_pkt <= 1'b0;
         last_q <= 1'b0;
      end else if (accept) begin
         in_pkt <= ~s_last_i;
         last_q <= s_last_i;
      end
   end
`else
   assign new_tgt = pick_idx;
   assign ptr_adv = xfer;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= ST_EMPTY;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      m_valid_o = '0;
`ifdef RR_DISPATCHER_PKT_EN
      s_ready_o = slot_free & (in_pkt | pick_found);
`else
      s_ready_o = slot_free & pick_found;
`endif
      case (state)
         ST_EMPTY: begin
            if (accept) state_nxt = ST_FULL;
         end
         ST_FULL: begin
            m_valid_o[tgt] = 1'b1;
            if (xfer && !accept) state_nxt = ST_EMPTY;
         end
         default: state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         m_data_o <= '0;
         tgt      <= '0;
         ptr      <= '0;
      end else begin
         if (accept) begin
            m_data_o <= s_data_i;
            tgt      <= new_tgt;
         end
         if (ptr_adv) ptr <= tgt_inc;
      end
   end

   assign m_sel_o = tgt;

endmodule

// File: tb/tb_rr_dispatcher.sv
// Directed bench for rr_dispatcher: cycle table plus reset and packet sequences.
module tb_rr_dispatcher;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int PW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  en;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic [N-1:0]  m_valid;
   logic [N-1:0]  m_ready;
   logic [DW-1:0] m_data;
   logic [PW-1:0] m_sel;
`ifdef RR_DISPATCHER_PKT_EN
   logic          s_last;
   logic          m_last;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rr_dispatcher #(.SLAVE_NUM(N), .DATA_WIDTH(DW)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .en_i      (en),
      .s_valid_i (s_valid),
      .s_ready_o (s_ready),
      .s_data_i  (s_data),
      .m_valid_o (m_valid),
      .m_ready_i (m_ready),
      .m_data_o  (m_data),
      .m_sel_o   (m_sel)
`ifdef RR_DISPATCHER_PKT_EN
      ,
      .s_last_i  (s_last),
      .m_last_o  (m_last)
`endif
   );

   typedef struct {
      logic [N-1:0]  en;
      logic          sv;
      logic [DW-1:0] data;
      logic [N-1:0]  mr;
      logic          e_sr;
      logic [N-1:0]  e_mv;
      logic [PW-1:0] e_sel;
      logic [DW-1:0] e_data;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [N-1:0] e, input logic sv, input logic [DW-1:0] d,
                      input logic [N-1:0] mr, input logic esr, input logic [N-1:0] emv,
                      input logic [PW-1:0] esel, input logic [DW-1:0] ed);
      vec_t v;
      v.en = e; v.sv = sv; v.data = d; v.mr = mr;
      v.e_sr = esr; v.e_mv = emv; v.e_sel = esel; v.e_data = ed;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [N-1:0] e, input logic sv, input logic [DW-1:0] d,
                        input logic [N-1:0] mr);
      en = e; s_valid = sv; s_data = d; m_ready = mr;
   endtask

   initial begin
      rst = 1'b1; en = '0; s_valid = 1'b0; s_data = '0; m_ready = '0;
`ifdef RR_DISPATCHER_PKT_EN
      s_last = 1'b1;
`endif
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("rst_m_valid", 64'(m_valid), 64'(0));
      chk("rst_m_data",  64'(m_data),  64'(0));
      chk("rst_m_sel",   64'(m_sel),   64'(0));
      chk("rst_s_ready_en0", 64'(s_ready), 64'(0));

      // round robin, full throughput
      add(4'hF,1,32'h0,4'hF, 1,4'h0,0,32'h0);
      add(4'hF,1,32'h1,4'hF, 1,4'h1,0,32'h0);
      add(4'hF,1,32'h2,4'hF, 1,4'h2,1,32'h1);
      add(4'hF,1,32'h3,4'hF, 1,4'h4,2,32'h2);
      add(4'hF,1,32'h4,4'hF, 1,4'h8,3,32'h3);
      add(4'hF,1,32'h5,4'hF, 1,4'h1,0,32'h4);
      add(4'hF,1,32'h6,4'hF, 1,4'h2,1,32'h5);
      add(4'hF,1,32'h7,4'hF, 1,4'h4,2,32'h6);
      add(4'hF,0,32'h0,4'hF, 1,4'h8,3,32'h7);
      add(4'hF,0,32'h0,4'hF, 1,4'h0,3,32'h7);
      // skip disabled sinks 0 and 2
      add(4'hA,1,32'hA0,4'hF, 1,4'h0,3,32'h7);
      add(4'hA,1,32'hA1,4'hF, 1,4'h2,1,32'hA0);
      add(4'hA,1,32'hA2,4'hF, 1,4'h8,3,32'hA1);
      add(4'hA,1,32'hA3,4'hF, 1,4'h2,1,32'hA2);
      add(4'hA,0,32'h0, 4'hF, 1,4'h8,3,32'hA3);
      // backpressure on sink 2 for five cycles
      add(4'hF,1,32'hB0,4'hF, 1,4'h0,3,32'hA3);
      add(4'hF,1,32'hB1,4'hF, 1,4'h1,0,32'hB0);
      add(4'hF,1,32'hB2,4'hF, 1,4'h2,1,32'hB1);
      for (int i = 0; i < 5; i++) add(4'hF,1,32'hB3,4'hB, 0,4'h4,2,32'hB2);
      add(4'hF,1,32'hB3,4'hF, 1,4'h4,2,32'hB2);
      add(4'hF,0,32'h0, 4'hF, 1,4'h8,3,32'hB3);
      // no enabled sinks, then sink 0 only
      add(4'h0,1,32'hC0,4'hF, 0,4'h0,3,32'hB3);
      add(4'h0,1,32'hC0,4'hF, 0,4'h0,3,32'hB3);
      add(4'h1,1,32'hC0,4'hF, 1,4'h0,3,32'hB3);
      add(4'h1,0,32'h0, 4'hF, 1,4'h1,0,32'hC0);
      // enable drop while FULL does not retarget
      add(4'hF,1,32'hD0,4'hF, 1,4'h0,0,32'hC0);
      add(4'h1,0,32'h0, 4'h0, 0,4'h2,1,32'hD0);
      add(4'h1,0,32'h0, 4'h2, 1,4'h2,1,32'hD0);
      add(4'hF,0,32'h0, 4'hF, 1,4'h0,1,32'hD0);

      foreach (tbl[i]) begin
         drive(tbl[i].en, tbl[i].sv, tbl[i].data, tbl[i].mr);
         #1;
         chk($sformatf("v%0d_s_ready", i), 64'(s_ready), 64'(tbl[i].e_sr));
         chk($sformatf("v%0d_m_valid", i), 64'(m_valid), 64'(tbl[i].e_mv));
         chk($sformatf("v%0d_m_sel",   i), 64'(m_sel),   64'(tbl[i].e_sel));
         chk($sformatf("v%0d_m_data",  i), 64'(m_data),  64'(tbl[i].e_data));
         tick();
      end

      // walk the pointer (now 2) to a beat held for sink 1, then reset asynchronously
      drive(4'hF,1,32'hF0,4'h0); tick();
      drive(4'hF,1,32'hF1,4'h4); tick();
      drive(4'hF,1,32'hF2,4'h8); tick();
      drive(4'hF,1,32'hF3,4'h1); tick();
      drive(4'hF,0,32'h0, 4'h0); #1;
      chk("pre_rst_m_valid", 64'(m_valid), 64'(4'h2));
      chk("pre_rst_m_data",  64'(m_data),  64'(32'hF3));
      rst = 1'b1;
      #1;
      chk("async_rst_m_valid", 64'(m_valid), 64'(0));
      chk("async_rst_m_data",  64'(m_data),  64'(0));
      chk("async_rst_m_sel",   64'(m_sel),   64'(0));
      tick();
      rst = 1'b0;
      drive(4'hF,1,32'h60,4'hF); #1;
      chk("post_rst_s_ready", 64'(s_ready), 64'(1));
      tick();
      drive(4'hF,0,32'h0,4'hF); #1;
      chk("post_rst_m_valid", 64'(m_valid), 64'(4'h1));
      chk("post_rst_m_sel",   64'(m_sel),   64'(0));
      chk("post_rst_m_data",  64'(m_data),  64'(32'h60));
      tick();

`ifdef RR_DISPATCHER_PKT_EN
      begin
         logic [DW-1:0] pd  [7];
         logic          pl  [7];
         logic [N-1:0]  pen [7];
         logic [N-1:0]  emv [7];
         logic [DW-1:0] edt [7];
         logic          elt [7];
         pd  = '{32'hA0, 32'hA1, 32'hA2, 32'hB0, 32'hB1, 32'hB2, 32'h0};
         pl  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
         pen = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE};
         emv = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2};
         edt = '{32'h0, 32'hA0, 32'hA1, 32'hA2, 32'hB0, 32'hB1, 32'hB2};
         elt = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
         rst = 1'b1; #1; tick(); rst = 1'b0;
         for (int i = 0; i < 7; i++) begin
            drive(pen[i], (i < 6), pd[i], 4'hF);
            s_last = pl[i];
            #1;
            chk($sformatf("pkt%0d_m_valid", i), 64'(m_valid), 64'(emv[i]));
            if (i > 0) begin
               chk($sformatf("pkt%0d_m_data", i), 64'(m_data), 64'(edt[i]));
               chk($sformatf("pkt%0d_m_last", i), 64'(m_last), 64'(elt[i]));
            end
            tick();
         end
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
